// File: rtl/jelly_pattern_generator_pkg.sv
// Shared constants for the AXI4-Stream test-pattern generator.
//   MODE_*  : pattern select values for param_mode
//   ST_*    : timing FSM state encoding (exposed on the debug state port)
//   bar_next: colour-bar index advance with saturation at the last bar
package jelly_pattern_generator_pkg;

  localparam logic [2:0] MODE_COORD   = 3'd0;
  localparam logic [2:0] MODE_BARS    = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_SOLID   = 3'd3;
  localparam logic [2:0] MODE_RAMP    = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_VBLANK = 2'd3;

  function automatic logic [2:0] bar_next(input logic [2:0] idx);
    return (idx == 3'd7) ? idx : idx + 3'd1;
  endfunction

endpackage

// File: rtl/jelly_pattern_generator_timing.sv
// Stage 1 of the pattern generator: FSM, x/y/blank counters, shadow
// parameter registers and the completed-frame counter.
//   aclk, areset          : clock, synchronous active-high reset
//   cke                   : pipeline advance; nothing changes without it
//   enable                : start / keep running
//   param_*               : live parameters, sampled only at frame start
//   busy, frame_count     : status
//   state                 : FSM state (debug)
//   valid, first, last    : current pixel is emitted / is (0,0) / ends a line
//   x, y, bar_idx         : current pixel coordinates and colour-bar index
//   mode, checker_shift,
//   color                 : shadowed pattern parameters for stage 2
module jelly_pattern_generator_timing
  import jelly_pattern_generator_pkg::*;
#(
  parameter int DATA_WIDTH        = 24,
  parameter int X_WIDTH           = 12,
  parameter int Y_WIDTH           = 12,
  parameter int BLANK_WIDTH       = 8,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         cke,
  input  logic                         enable,
  input  logic                         param_oneshot,
  input  logic [2:0]                   param_mode,
  input  logic [X_WIDTH-1:0]           param_x_last,
  input  logic [Y_WIDTH-1:0]           param_y_last,
  input  logic [BLANK_WIDTH-1:0]       param_h_blank,
  input  logic [BLANK_WIDTH-1:0]       param_v_blank,
  input  logic [X_WIDTH-1:0]           param_bar_width,
  input  logic [3:0]                   param_checker_shift,
  input  logic [DATA_WIDTH-1:0]        param_color,
  output logic                         busy,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic [1:0]                   state,
  output logic                         valid,
  output logic                         first,
  output logic                         last,
  output logic [X_WIDTH-1:0]           x,
  output logic [Y_WIDTH-1:0]           y,
  output logic [2:0]                   bar_idx,
  output logic [2:0]                   mode,
  output logic [3:0]                   checker_shift,
  output logic [DATA_WIDTH-1:0]        color
);

  logic                   sh_oneshot;
  logic [X_WIDTH-1:0]     sh_x_last;
  logic [Y_WIDTH-1:0]     sh_y_last;
  logic [BLANK_WIDTH-1:0] sh_h_blank;
  logic [BLANK_WIDTH-1:0] sh_v_blank;
  logic [X_WIDTH-1:0]     sh_bar_width;
  logic [BLANK_WIDTH:0]   cnt;
  logic [X_WIDTH-1:0]     bar_cnt;

  // The last line is followed by its own h_blank plus the frame's v_blank,
  // so VBLANK runs for the sum and HBLANK is not entered on the last line.
  logic [BLANK_WIDTH:0] vb_total;
  logic line_end, h_done, frame_done, stop, load;

  assign vb_total   = {1'b0, sh_h_blank} + {1'b0, sh_v_blank};
  assign line_end   = (x == sh_x_last);
  assign h_done     = (cnt == {1'b0, sh_h_blank} - 1'b1);
  // With no blanking at all the frame ends on its last pixel, so a
  // continuous stream carries no bubble between frames.
  assign frame_done = (state == ST_ACTIVE && line_end && y == sh_y_last && vb_total == '0)
                   || (state == ST_VBLANK && cnt == vb_total - 1'b1);
  assign stop       = sh_oneshot || !enable;
  assign load       = (state == ST_IDLE && enable) || (frame_done && !stop);

  assign valid = (state == ST_ACTIVE);
  assign first = valid && x == '0 && y == '0;
  assign last  = valid && line_end;

  // Shadow registers: parameters only take effect at a frame boundary.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sh_oneshot    <= 1'b0;
      mode          <= '0;
      sh_x_last     <= '0;
      sh_y_last     <= '0;
      sh_h_blank    <= '0;
      sh_v_blank    <= '0;
      sh_bar_width  <= '0;
      checker_shift <= '0;
      color         <= '0;
    end else if (cke && load) begin
      sh_oneshot    <= param_oneshot;
      mode          <= param_mode;
      sh_x_last     <= param_x_last;
      sh_y_last     <= param_y_last;
      sh_h_blank    <= param_h_blank;
      sh_v_blank    <= param_v_blank;
      sh_bar_width  <= param_bar_width;
      checker_shift <= param_checker_shift;
      color         <= param_color;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      frame_count <= '0;
      x           <= '0;
      y           <= '0;
      cnt         <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
    end else if (cke) begin
      if (frame_done) begin
        frame_count <= frame_count + 1'b1;
        x           <= '0;
        y           <= '0;
        cnt         <= '0;
        bar_cnt     <= '0;
        bar_idx     <= '0;
        if (stop) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          state <= ST_ACTIVE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable) begin
              state   <= ST_ACTIVE;
              busy    <= 1'b1;
              x       <= '0;
              y       <= '0;
              cnt     <= '0;
              bar_cnt <= '0;
              bar_idx <= '0;
            end
          end
          ST_ACTIVE: begin
            if (line_end) begin
              x       <= '0;
              cnt     <= '0;
              bar_cnt <= '0;
              bar_idx <= '0;
              if (y == sh_y_last) begin
                y     <= '0;
                state <= ST_VBLANK;
              end else begin
                y <= y + 1'b1;
                if (sh_h_blank != '0) state <= ST_HBLANK;
              end
            end else begin
              x <= x + 1'b1;
              if (bar_cnt == sh_bar_width) begin
                bar_cnt <= '0;
                bar_idx <= bar_next(bar_idx);
              end else begin
                bar_cnt <= bar_cnt + 1'b1;
              end
            end
          end
          ST_HBLANK: begin
            if (h_done) begin
              cnt   <= '0;
              state <= ST_ACTIVE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_VBLANK: cnt <= cnt + 1'b1;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/jelly_pattern_generator_axi4s_ex.sv
// AXI4-Stream video test-pattern source (top level).
//   aclk, areset        : clock, synchronous active-high reset
//   enable, busy        : start/keep-running request, generator active
//   frame_count         : completed frames, wrapping
//   param_*             : frame geometry, blanking and pattern selection
//   m_axi4s_*           : video stream out (tuser = start of frame,
//                         tlast = end of line)
//   dbg_state           : timing FSM state
// Handshake: a beat transfers on a clock edge where tvalid && tready; while
// tvalid is high and tready low, tdata/tlast/tuser/tvalid hold and the whole
// pipeline freezes. The pipeline advances whenever the output register is
// empty or being drained (cke).
module jelly_pattern_generator_axi4s_ex
  import jelly_pattern_generator_pkg::*;
#(
  parameter  int COMPONENTS        = 3,
  parameter  int COMPONENT_WIDTH   = 8,
  parameter  int X_WIDTH           = 12,
  parameter  int Y_WIDTH           = 12,
  parameter  int BLANK_WIDTH       = 8,
  parameter  int FRAME_COUNT_WIDTH = 16,
  localparam int DATA_WIDTH        = COMPONENTS * COMPONENT_WIDTH
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         enable,
  output logic                         busy,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  input  logic                         param_oneshot,
  input  logic [2:0]                   param_mode,
  input  logic [X_WIDTH-1:0]           param_x_last,
  input  logic [Y_WIDTH-1:0]           param_y_last,
  input  logic [BLANK_WIDTH-1:0]       param_h_blank,
  input  logic [BLANK_WIDTH-1:0]       param_v_blank,
  input  logic [X_WIDTH-1:0]           param_bar_width,
  input  logic [3:0]                   param_checker_shift,
  input  logic [DATA_WIDTH-1:0]        param_color,
  output logic [DATA_WIDTH-1:0]        m_axi4s_tdata,
  output logic                         m_axi4s_tlast,
  output logic                         m_axi4s_tuser,
  output logic                         m_axi4s_tvalid,
  input  logic                         m_axi4s_tready,
  output logic [1:0]                   dbg_state
);

  logic                  cke;
  logic                  s_valid, s_first, s_last;
  logic [X_WIDTH-1:0]    s_x;
  logic [Y_WIDTH-1:0]    s_y;
  logic [2:0]            s_bar_idx, s_mode;
  logic [3:0]            s_shift;
  logic [DATA_WIDTH-1:0] s_color;
  logic [DATA_WIDTH-1:0] pix;
  logic [2:0]            bar_on;
  logic                  chk;

  assign cke = !m_axi4s_tvalid || m_axi4s_tready;

  jelly_pattern_generator_timing #(
    .DATA_WIDTH        (DATA_WIDTH),
    .X_WIDTH           (X_WIDTH),
    .Y_WIDTH           (Y_WIDTH),
    .BLANK_WIDTH       (BLANK_WIDTH),
    .FRAME_COUNT_WIDTH (FRAME_COUNT_WIDTH)
  ) u_timing (
    .aclk                (aclk),
    .areset              (areset),
    .cke                 (cke),
    .enable              (enable),
    .param_oneshot       (param_oneshot),
    .param_mode          (param_mode),
    .param_x_last        (param_x_last),
    .param_y_last        (param_y_last),
    .param_h_blank       (param_h_blank),
    .param_v_blank       (param_v_blank),
    .param_bar_width     (param_bar_width),
    .param_checker_shift (param_checker_shift),
    .param_color         (param_color),
    .busy                (busy),
    .frame_count         (frame_count),
    .state               (dbg_state),
    .valid               (s_valid),
    .first               (s_first),
    .last                (s_last),
    .x                   (s_x),
    .y                   (s_y),
    .bar_idx             (s_bar_idx),
    .mode                (s_mode),
    .checker_shift       (s_shift),
    .color               (s_color)
  );

  // Bit 'shift' of each coordinate is bit 0 of (coord >> shift); shifts past
  // the counter width select nothing and read as 0.
  assign chk    = |(s_x & (X_WIDTH'(1) << s_shift)) ^ |(s_y & (Y_WIDTH'(1) << s_shift));
  // Bar 0 is white (all components on), counting down to black at bar 7.
  assign bar_on = 3'd7 - s_bar_idx;

  always_comb begin
    pix = '0;
    case (s_mode)
      MODE_COORD: begin
        for (int c = 0; c < COMPONENTS; c++) begin
          if (c == 0)      pix[c*COMPONENT_WIDTH +: COMPONENT_WIDTH] = COMPONENT_WIDTH'(s_x);
          else if (c == 1) pix[c*COMPONENT_WIDTH +: COMPONENT_WIDTH] = COMPONENT_WIDTH'(s_y);
          else             pix[c*COMPONENT_WIDTH +: COMPONENT_WIDTH] = COMPONENT_WIDTH'(frame_count);
        end
      end
      MODE_BARS: begin
        for (int c = 0; c < COMPONENTS; c++) begin
          pix[c*COMPONENT_WIDTH +: COMPONENT_WIDTH] = {COMPONENT_WIDTH{bar_on[c % 3]}};
        end
      end
      MODE_CHECKER: pix = {DATA_WIDTH{chk}};
      MODE_SOLID:   pix = s_color;
      MODE_RAMP: begin
        for (int c = 0; c < COMPONENTS; c++) begin
          pix[c*COMPONENT_WIDTH +: COMPONENT_WIDTH] = COMPONENT_WIDTH'(s_x);
        end
      end
      default: pix = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tdata  <= '0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tuser  <= 1'b0;
    end else if (cke) begin
      m_axi4s_tvalid <= s_valid;
      m_axi4s_tdata  <= pix;
      m_axi4s_tlast  <= s_last;
      m_axi4s_tuser  <= s_first;
    end
  end

endmodule

// File: tb/tb_jelly_pattern_generator_axi4s_ex.sv
module tb_jelly_pattern_generator_axi4s_ex;
  import jelly_pattern_generator_pkg::*;

  localparam int COMPONENTS = 3;
  localparam int CW         = 8;
  localparam int DW         = COMPONENTS * CW;
  localparam int XW         = 12;
  localparam int YW         = 12;
  localparam int BW         = 8;
  localparam int FW         = 16;
  localparam int SBW        = DW + 2;

  logic          aclk = 1'b0;
  logic          areset;
  logic          enable;
  logic          busy;
  logic [FW-1:0] frame_count;
  logic          param_oneshot;
  logic [2:0]    param_mode;
  logic [XW-1:0] param_x_last;
  logic [YW-1:0] param_y_last;
  logic [BW-1:0] param_h_blank;
  logic [BW-1:0] param_v_blank;
  logic [XW-1:0] param_bar_width;
  logic [3:0]    param_checker_shift;
  logic [DW-1:0] param_color;
  logic [DW-1:0] m_axi4s_tdata;
  logic          m_axi4s_tlast;
  logic          m_axi4s_tuser;
  logic          m_axi4s_tvalid;
  logic          m_axi4s_tready;
  logic [1:0]    dbg_state;

  jelly_pattern_generator_axi4s_ex #(
    .COMPONENTS        (COMPONENTS),
    .COMPONENT_WIDTH   (CW),
    .X_WIDTH           (XW),
    .Y_WIDTH           (YW),
    .BLANK_WIDTH       (BW),
    .FRAME_COUNT_WIDTH (FW)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .enable              (enable),
    .busy                (busy),
    .frame_count         (frame_count),
    .param_oneshot       (param_oneshot),
    .param_mode          (param_mode),
    .param_x_last        (param_x_last),
    .param_y_last        (param_y_last),
    .param_h_blank       (param_h_blank),
    .param_v_blank       (param_v_blank),
    .param_bar_width     (param_bar_width),
    .param_checker_shift (param_checker_shift),
    .param_color         (param_color),
    .m_axi4s_tdata       (m_axi4s_tdata),
    .m_axi4s_tlast       (m_axi4s_tlast),
    .m_axi4s_tuser       (m_axi4s_tuser),
    .m_axi4s_tvalid      (m_axi4s_tvalid),
    .m_axi4s_tready      (m_axi4s_tready),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int fc_model = 0;
  int beat_total = 0;
  logic sb_on = 1'b1;
  logic rand_ready = 1'b0;
  logic [SBW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_pixel(input int mode, input int x, input int y,
                                                input int bw, input int sh,
                                                input logic [DW-1:0] color, input int fc);
    logic [DW-1:0] p;
    int b, v, comp;
    int ones;
    ones = (1 << CW) - 1;
    p = '0;
    for (int c = 0; c < COMPONENTS; c++) begin
      comp = 0;
      case (mode)
        0: comp = (c == 0) ? x : (c == 1) ? y : fc;
        1: begin
          b = x / (bw + 1);
          if (b > 7) b = 7;
          v = 7 - b;
          comp = ((v >> (c % 3)) & 1) != 0 ? ones : 0;
        end
        2: comp = (((x >> sh) ^ (y >> sh)) & 1) != 0 ? ones : 0;
        4: comp = x;
        default: comp = 0;
      endcase
      p[c*CW +: CW] = comp[CW-1:0];
    end
    if (mode == 3) p = color;
    return p;
  endfunction

  task automatic push_frame(input int mode, input int xl, input int yl, input int bw,
                            input int sh, input logic [DW-1:0] color, input int fc);
    logic [SBW-1:0] e;
    for (int y = 0; y <= yl; y++) begin
      for (int x = 0; x <= xl; x++) begin
        e = {(x == 0 && y == 0), (x == xl), model_pixel(mode, x, y, bw, sh, color, fc)};
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic           prev_stall = 1'b0;
  logic [SBW:0]   prev_beat  = '0;

  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, prev_beat);
      prev_stall = m_axi4s_tvalid && !m_axi4s_tready;
      prev_beat  = {m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        beat_total++;
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat: got unexpected beat %0h, expected none",
                     {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata});
          end else begin
            check("beat", {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Ready driver: changes well away from the active edge.
  initial begin
    m_axi4s_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      m_axi4s_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic set_params(input int mode, input int xl, input int yl, input int hb,
                            input int vb, input int bw, input int sh,
                            input logic [DW-1:0] color, input logic oneshot);
    param_mode          = 3'(mode);
    param_x_last        = XW'(xl);
    param_y_last        = YW'(yl);
    param_h_blank       = BW'(hb);
    param_v_blank       = BW'(vb);
    param_bar_width     = XW'(bw);
    param_checker_shift = 4'(sh);
    param_color         = color;
    param_oneshot       = oneshot;
  endtask

  task automatic start_pulse();
    tick();
    enable = 1'b1;
    @(posedge aclk);
    #1;
    enable = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && !m_axi4s_tvalid && exp_q.size() == 0) break;
    end
    check(tag, (!busy && !m_axi4s_tvalid && exp_q.size() == 0), 1);
  endtask

  task automatic wait_beats(input string tag, input int start, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (beat_total - start >= n) break;
      tick();
    end
    check(tag, (beat_total - start >= n), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int mode, xl, yl, bw, sh, ph;
    logic [DW-1:0] color;
    logic exp_v;

    areset = 1'b1;
    enable = 1'b0;
    set_params(0, 0, 0, 0, 0, 0, 0, '0, 1'b0);
    repeat (4) tick();

    // Reset state
    check("rst_tvalid", m_axi4s_tvalid, 0);
    check("rst_tdata",  m_axi4s_tdata,  0);
    check("rst_tlast",  m_axi4s_tlast,  0);
    check("rst_tuser",  m_axi4s_tuser,  0);
    check("rst_busy",   busy,           0);
    check("rst_fc",     frame_count,    0);
    check("rst_state",  dbg_state,      ST_IDLE);
    areset = 1'b0;
    tick();

    // Basic one-shot coordinate frame, tready held high
    set_params(0, 3, 1, 0, 0, 0, 0, '0, 1'b1);
    push_frame(0, 3, 1, 0, 0, '0, fc_model);
    fc_model++;
    start = beat_total;
    start_pulse();
    wait_idle("a_done", 200);
    check("a_fc", frame_count, fc_model);
    check("a_beats", beat_total - start, 8);

    // Same frame with random back-pressure
    rand_ready = 1'b1;
    set_params(0, 3, 1, 0, 0, 0, 0, '0, 1'b1);
    push_frame(0, 3, 1, 0, 0, '0, fc_model);
    fc_model++;
    start_pulse();
    wait_idle("b_done", 400);
    check("b_fc", frame_count, fc_model);

    // Random frames; parameters are scrambled right after start
    for (int f = 0; f < 6; f++) begin
      mode  = $urandom_range(0, 7);
      xl    = $urandom_range(0, 5);
      yl    = $urandom_range(0, 3);
      bw    = $urandom_range(0, 3);
      sh    = $urandom_range(0, 2);
      color = DW'($urandom());
      set_params(mode, xl, yl, $urandom_range(0, 3), $urandom_range(0, 3), bw, sh, color, 1'b1);
      push_frame(mode, xl, yl, bw, sh, color, fc_model);
      fc_model++;
      start_pulse();
      set_params($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 9),
                 $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                 $urandom_range(0, 9), DW'($urandom()), 1'($urandom_range(0, 1)));
      wait_idle("r_done", 600);
      check("r_fc", frame_count, fc_model);
    end
    rand_ready = 1'b0;

    // Colour bars, two pixels per bar
    set_params(1, 15, 0, 0, 0, 1, 0, '0, 1'b1);
    push_frame(1, 15, 0, 1, 0, '0, fc_model);
    fc_model++;
    start_pulse();
    wait_idle("bars_done", 200);

    // Mid-frame parameter change takes effect only on the next frame
    set_params(0, 3, 1, 1, 0, 0, 0, '0, 1'b0);
    push_frame(0, 3, 1, 0, 0, '0, fc_model);
    fc_model++;
    push_frame(0, 1, 1, 0, 0, '0, fc_model);
    fc_model++;
    start = beat_total;
    tick();
    enable = 1'b1;
    wait_beats("m_mid", start, 2, 100);
    param_x_last  = XW'(1);
    param_oneshot = 1'b1;
    wait_beats("m_next", start, 9, 100);
    enable = 1'b0;
    wait_idle("m_done", 200);
    check("m_fc", frame_count, fc_model);

    // Continuous run with blanking: 2 beats, 2 idle, 2 beats, 7 idle
    sb_on = 1'b0;
    set_params(4, 1, 1, 2, 5, 0, 0, '0, 1'b0);
    tick();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_axi4s_tvalid) break;
      tick();
    end
    check("c_start", m_axi4s_tvalid, 1);
    for (int i = 0; i < 39; i++) begin
      if (i > 0) tick();
      ph = i % 13;
      exp_v = (ph == 0 || ph == 1 || ph == 4 || ph == 5);
      check("c_valid", m_axi4s_tvalid, exp_v);
      if (exp_v) begin
        check("c_data", m_axi4s_tdata, model_pixel(4, ph % 2, 0, 0, 0, '0, 0));
        check("c_last", m_axi4s_tlast, (ph % 2));
      end
      if (ph == 0) check("c_fc", frame_count, FW'(fc_model + i / 13));
    end
    enable = 1'b0;
    wait_idle("c_done", 200);

    // Reset in the middle of a frame
    set_params(4, 3, 1, 0, 0, 0, 0, '0, 1'b0);
    push_frame(4, 3, 1, 0, 0, '0, 0);
    sb_on = 1'b1;
    start = beat_total;
    tick();
    enable = 1'b1;
    wait_beats("x_beats", start, 5, 100);
    areset = 1'b1;
    sb_on  = 1'b0;
    exp_q.delete();
    tick();
    check("x_tvalid", m_axi4s_tvalid, 0);
    check("x_tdata",  m_axi4s_tdata,  0);
    check("x_tlast",  m_axi4s_tlast,  0);
    check("x_tuser",  m_axi4s_tuser,  0);
    check("x_busy",   busy,           0);
    check("x_fc",     frame_count,    0);
    fc_model = 0;
    set_params(0, 3, 1, 0, 0, 0, 0, '0, 1'b1);
    push_frame(0, 3, 1, 0, 0, '0, fc_model);
    fc_model++;
    sb_on  = 1'b1;
    areset = 1'b0;
    start  = beat_total;
    wait_beats("x_restart", start, 1, 100);
    enable = 1'b0;
    wait_idle("x_done", 200);
    check("x_fc_after", frame_count, fc_model);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
